adc_scheduler: RTL

Round-robin sampling controller that shares one dual-channel 12-bit SPI ADC front end between the two player inputs. It sits between the ADC transaction engine and the game logic. It paces conversions from a fixed sample-rate divider and issues per-channel requests over a req/done handshake. It latches results into the p1data/p2data registers consumed by the single- and multi-player screen logic, and emits one round_tick per completed sampling round to pace the game state machine.

---
 rtl/adc_scheduler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/adc_scheduler.sv
// adc_scheduler: paces rounds of ADC conversions for two player inputs
// and latches per-player samples, with timeout and overrun reporting.
`timescale 1ns/1ps

module adc_scheduler #(
  parameter int SAMPLE_DIV = 48000,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        multi,
  output logic        adc_req,
  output logic        adc_ch,
  input  logic        adc_done,
  input  logic [11:0] adc_data,
  output logic [11:0] p1data,
  output logic [11:0] p2data,
  output logic        p1_valid,
  output logic        p2_valid,
  output logic        round_tick,
  output logic        timeout_err,
  output logic        overrun
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [19:0] DIV_LAST = 20'(SAMPLE_DIV - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_REQ_P1,
    S_REQ_P2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [19:0]   r_div;
  logic [TW-1:0] r_to;
  logic          r_round_multi;

  logic          r_req;
  logic          r_ch;
  logic [11:0]   r_p1data;
  logic [11:0]   r_p2data;
  logic          r_p1_valid;
  logic          r_p2_valid;
  logic          r_tick;
  logic          r_to_err;
  logic          r_ovr;

  logic w_div_wrap;
  logic w_tick;
  logic w_expire;
  logic w_adv;
  logic w_start;
  logic w_p1_upd;
  logic w_p2_upd;
  logic w_end;
  logic w_to_hit;
  logic w_busy;

  assign w_div_wrap = (r_div == DIV_LAST);
  assign w_tick     = enable && w_div_wrap;
  assign w_expire   = (r_to == TO_LAST);
  assign w_adv      = adc_done || w_expire;
  assign w_busy     = (r_state != S_WAIT);

  // Sample-rate divider; held at zero while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
    end else if (!enable || w_div_wrap) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 20'd1;
    end
  end

  // Per-request watchdog; restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to <= '0;
    end else if (!w_busy || (w_state_nxt != r_state)) begin
      r_to <= '0;
    end else begin
      r_to <= r_to + TW'(1);
    end
  end

  // State register and round-mode snapshot taken at round start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_WAIT;
      r_round_multi <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_round_multi <= multi;
      end
    end
  end

  // Next-state logic; a timeout advances exactly like a done,
  // and a done on the expiry cycle counts as a done.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_p1_upd    = 1'b0;
    w_p2_upd    = 1'b0;
    w_end       = 1'b0;
    w_to_hit    = 1'b0;
    unique case (r_state)
      S_WAIT: begin
        if (w_tick) begin
          w_start     = 1'b1;
          w_state_nxt = S_REQ_P1;
        end
      end
      S_REQ_P1: begin
        if (w_adv) begin
          w_p1_upd = adc_done;
          w_to_hit = !adc_done;
          if (r_round_multi) begin
            w_state_nxt = S_REQ_P2;
          end else begin
            w_state_nxt = S_WAIT;
            w_end       = 1'b1;
          end
        end
      end
      S_REQ_P2: begin
        if (w_adv) begin
          w_p2_upd    = adc_done;
          w_to_hit    = !adc_done;
          w_state_nxt = S_WAIT;
          w_end       = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_WAIT;
      end
    endcase
  end

  // Registered outputs derived from the upcoming state and events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req      <= 1'b0;
      r_ch       <= 1'b0;
      r_p1data   <= '0;
      r_p2data   <= '0;
      r_p1_valid <= 1'b0;
      r_p2_valid <= 1'b0;
      r_tick     <= 1'b0;
      r_to_err   <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_req      <= (w_state_nxt != S_WAIT);
      r_ch       <= (w_state_nxt == S_REQ_P2);
      r_p1_valid <= w_p1_upd;
      r_p2_valid <= w_p2_upd;
      r_tick     <= w_end;
      r_to_err   <= r_to_err | w_to_hit;
      r_ovr      <= r_ovr | (w_tick && w_busy);
      if (w_p1_upd) begin
        r_p1data <= adc_data;
      end
      if (w_p2_upd) begin
        r_p2data <= adc_data;
      end
    end
  end

  assign adc_req     = r_req;
  assign adc_ch      = r_ch;
  assign p1data      = r_p1data;
  assign p2data      = r_p2data;
  assign p1_valid    = r_p1_valid;
  assign p2_valid    = r_p2_valid;
  assign round_tick  = r_tick;
  assign timeout_err = r_to_err;
  assign overrun     = r_ovr;

endmodule
